// File: rtl/svunit_report_tx_if.sv
// Event-in / byte-out stream bundle for the SVUnit report transmitter.
// The master modport is the system side; the slave modport is the transmitter itself.
interface svunit_report_tx_if #(
  parameter int unsigned ID_W = 8
);
  logic            evt_valid;
  logic            evt_ready;
  logic            evt_pass;
  logic [ID_W-1:0] evt_id;
  logic            tx_valid;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            tx_last;

  modport master (
    output evt_valid, evt_pass, evt_id, tx_ready,
    input  evt_ready, tx_valid, tx_data, tx_last
  );

  modport slave (
    input  evt_valid, evt_pass, evt_id, tx_ready,
    output evt_ready, tx_valid, tx_data, tx_last
  );
endinterface

// File: rtl/svunit_report_tx.sv
// SVUnit check-result transmitter: tallies pass/fail events, buffers them and
// serialises CHECK / SUMMARY records as framed bytes on a valid/ready stream.
module svunit_report_tx #(
  parameter int unsigned ID_W       = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  svunit_report_tx_if.slave bus,
  input  logic              done,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt,
  output logic              busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = ID_W + 1;

  typedef enum logic [2:0] {
    IDLE, CHK_HDR, CHK_ID, SUM0, SUM1, SUM2, SUM3, SUM4
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            push;
  logic            pop;

  logic            sum_pend;
  logic            sum_start;
  logic            sum_done;
  logic            tx_hs;

  logic            cur_pass;
  logic [ID_W-1:0] cur_id;
  logic [15:0]     pass_q;
  logic [15:0]     fail_q;
  logic [15:0]     snap_pass;
  logic [15:0]     snap_fail;

  // Extra pointer bit separates full from empty when the index bits match.
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.evt_ready = !fifo_full && !sum_pend;
  assign push          = bus.evt_valid && bus.evt_ready;
  assign pop           = (state == IDLE) && !fifo_empty;
  assign sum_start     = (state == IDLE) && fifo_empty && sum_pend;
  assign tx_hs         = bus.tx_valid && bus.tx_ready;
  assign sum_done      = (state == SUM4) && tx_hs;

  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign busy     = !fifo_empty || (state != IDLE) || sum_pend;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {bus.evt_pass, bus.evt_id};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pass <= 1'b0;
      cur_id   <= '0;
    end else if (pop) begin
      {cur_pass, cur_id} <= fifo_mem[rd_ptr[AW-1:0]];
    end
  end

  // Totals are frozen as the D0 byte goes out so the record is self-consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_pass <= '0;
      snap_fail <= '0;
    end else if (sum_start) begin
      snap_pass <= pass_q;
      snap_fail <= fail_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sum_done) begin
      pass_q <= '0;
      fail_q <= '0;
    end else if (push) begin
      if (bus.evt_pass) begin
        if (pass_q != '1) pass_q <= pass_q + 16'd1;
      end else begin
        if (fail_q != '1) fail_q <= fail_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || sum_done) begin
      sum_pend <= 1'b0;
    end else if (done) begin
      sum_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!fifo_empty)   state_nxt = CHK_HDR;
        else if (sum_pend) state_nxt = SUM0;
      end
      CHK_HDR: if (tx_hs) state_nxt = CHK_ID;
      CHK_ID:  if (tx_hs) state_nxt = IDLE;
      SUM0:    if (tx_hs) state_nxt = SUM1;
      SUM1:    if (tx_hs) state_nxt = SUM2;
      SUM2:    if (tx_hs) state_nxt = SUM3;
      SUM3:    if (tx_hs) state_nxt = SUM4;
      SUM4:    if (tx_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid = 1'b1;
    bus.tx_last  = 1'b0;
    bus.tx_data  = '0;
    case (state)
      IDLE:    bus.tx_valid = 1'b0;
      CHK_HDR: bus.tx_data  = {7'h60, cur_pass};
      CHK_ID: begin
        bus.tx_data = 8'(cur_id);
        bus.tx_last = 1'b1;
      end
      SUM0:    bus.tx_data  = 8'hD0;
      SUM1:    bus.tx_data  = snap_pass[15:8];
      SUM2:    bus.tx_data  = snap_pass[7:0];
      SUM3:    bus.tx_data  = snap_fail[15:8];
      SUM4: begin
        bus.tx_data = snap_fail[7:0];
        bus.tx_last = 1'b1;
      end
      default: bus.tx_valid = 1'b0;
    endcase
  end

  a_tx_hold: assert property (@(posedge clk) disable iff (rst)
    bus.tx_valid && !bus.tx_ready |=>
      bus.tx_valid && $stable(bus.tx_data) && $stable(bus.tx_last));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fifo_full |-> !push);

endmodule

// File: tb/tb_svunit_report_tx.sv
// Directed bench for svunit_report_tx: record framing, backpressure, FIFO-full
// blocking, summary ordering, counter saturation and mid-record reset.
module tb_svunit_report_tx;
  logic        clk;
  logic        rst;
  logic        done;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic        busy;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  svunit_report_tx_if #(.ID_W(8)) bus ();

  svunit_report_tx #(.ID_W(8), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .done     (done),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    done          = 1'b0;
    bus.evt_valid = 1'b0;
    bus.evt_pass  = 1'b0;
    bus.evt_id    = '0;
    bus.tx_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_evt(input logic p, input logic [7:0] id);
    bus.evt_valid = 1'b1;
    bus.evt_pass  = p;
    bus.evt_id    = id;
    tick();
    bus.evt_valid = 1'b0;
  endtask

  // Waits (bounded) for a presented byte, applies random backpressure, then takes it.
  task automatic get_byte(input string tag, input logic [7:0] d, input logic l,
                          input int unsigned pct);
    int unsigned waited = 0;
    while (!(bus.tx_valid && (waited >= 6 || $urandom_range(99) < pct)) && waited < 40) begin
      bus.tx_ready = 1'b0;
      tick();
      waited++;
    end
    if (!bus.tx_valid) begin
      check({tag, "_valid"}, 32'(bus.tx_valid), 32'd1);
      return;
    end
    check(tag, {23'd0, bus.tx_last, bus.tx_data}, {23'd0, l, d});
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    // 1: reset state and single-event latency
    do_reset();
    check("rst_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_data",  32'(bus.tx_data),  32'd0);
    check("rst_last",  32'(bus.tx_last),  32'd0);
    check("rst_pass",  32'(pass_cnt),     32'd0);
    check("rst_fail",  32'(fail_cnt),     32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_rdy",   32'(bus.evt_ready), 32'd1);
    bus.tx_ready = 1'b1;
    send_evt(1'b1, 8'h05);
    check("t1_idle_valid", 32'(bus.tx_valid), 32'd0);
    check("t1_pass",       32'(pass_cnt),     32'd1);
    check("t1_busy",       32'(busy),         32'd1);
    tick();
    check("t1_hdr", {22'd0, bus.tx_valid, bus.tx_last, bus.tx_data}, {22'd0, 1'b1, 1'b0, 8'hC1});
    tick();
    check("t1_id",  {22'd0, bus.tx_valid, bus.tx_last, bus.tx_data}, {22'd0, 1'b1, 1'b1, 8'h05});
    tick();
    check("t1_end_valid", 32'(bus.tx_valid), 32'd0);
    check("t1_end_busy",  32'(busy),         32'd0);
    check("t1_fail",      32'(fail_cnt),     32'd0);

    // 2: stalled output, FIFO fills, full blocks push even while popping
    do_reset();
    for (int unsigned i = 0; i < 5; i++) begin
      bus.evt_valid = 1'b1;
      bus.evt_pass  = i[0];
      bus.evt_id    = 8'(i + 1);
      check("t2_rdy", 32'(bus.evt_ready), 32'd1);
      tick();
    end
    bus.evt_pass = 1'b1;
    bus.evt_id   = 8'h06;
    check("t2_full_rdy", 32'(bus.evt_ready), 32'd0);
    check("t2_pass", 32'(pass_cnt), 32'd2);
    check("t2_fail", 32'(fail_cnt), 32'd3);
    for (int unsigned i = 0; i < 3; i++) begin
      check("t2_stall", {22'd0, bus.tx_valid, bus.tx_last, bus.tx_data}, {22'd0, 1'b1, 1'b0, 8'hC0});
      tick();
    end
    check("t2_stall_pass", 32'(pass_cnt), 32'd2);
    bus.tx_ready = 1'b1;
    tick();
    check("t2_id1", {23'd0, bus.tx_last, bus.tx_data}, {23'd0, 1'b1, 8'h01});
    check("t2_id1_rdy", 32'(bus.evt_ready), 32'd0);
    tick();
    check("t2_idle_valid", 32'(bus.tx_valid), 32'd0);
    check("t2_idle_full",  32'(bus.evt_ready), 32'd0);
    tick();
    check("t2_room_rdy", 32'(bus.evt_ready), 32'd1);
    bus.evt_valid = 1'b0;
    get_byte("t2_b2h", 8'hC1, 1'b0, 100);
    get_byte("t2_b2i", 8'h02, 1'b1, 100);
    get_byte("t2_b3h", 8'hC0, 1'b0, 100);
    get_byte("t2_b3i", 8'h03, 1'b1, 100);
    get_byte("t2_b4h", 8'hC1, 1'b0, 100);
    get_byte("t2_b4i", 8'h04, 1'b1, 100);
    get_byte("t2_b5h", 8'hC0, 1'b0, 100);
    get_byte("t2_b5i", 8'h05, 1'b1, 100);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_pass_end", 32'(pass_cnt), 32'd2);
    check("t2_fail_end", 32'(fail_cnt), 32'd3);

    // 3: events then summary, with random backpressure
    do_reset();
    send_evt(1'b1, 8'h11);
    send_evt(1'b0, 8'h22);
    send_evt(1'b0, 8'h33);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t3_pend_rdy", 32'(bus.evt_ready), 32'd0);
    check("t3_pass", 32'(pass_cnt), 32'd1);
    check("t3_fail", 32'(fail_cnt), 32'd2);
    get_byte("t3_c1h", 8'hC1, 1'b0, 60);
    get_byte("t3_c1i", 8'h11, 1'b1, 60);
    get_byte("t3_c2h", 8'hC0, 1'b0, 60);
    get_byte("t3_c2i", 8'h22, 1'b1, 60);
    get_byte("t3_c3h", 8'hC0, 1'b0, 60);
    get_byte("t3_c3i", 8'h33, 1'b1, 60);
    get_byte("t3_s0",  8'hD0, 1'b0, 60);
    get_byte("t3_s1",  8'h00, 1'b0, 60);
    get_byte("t3_s2",  8'h01, 1'b0, 60);
    get_byte("t3_s3",  8'h00, 1'b0, 60);
    get_byte("t3_s4",  8'h02, 1'b1, 60);
    check("t3_pass_clr", 32'(pass_cnt), 32'd0);
    check("t3_fail_clr", 32'(fail_cnt), 32'd0);
    check("t3_busy",     32'(busy),     32'd0);
    check("t3_rdy",      32'(bus.evt_ready), 32'd1);

    // 4: fail counter saturation
    do_reset();
    force dut.fail_q = 16'hFFFE;
    tick();
    release dut.fail_q;
    check("t4_preload", 32'(fail_cnt), 32'h0000FFFE);
    send_evt(1'b0, 8'h07);
    check("t4_ffff", 32'(fail_cnt), 32'h0000FFFF);
    send_evt(1'b0, 8'h08);
    check("t4_sat", 32'(fail_cnt), 32'h0000FFFF);
    get_byte("t4_c1h", 8'hC0, 1'b0, 100);
    get_byte("t4_c1i", 8'h07, 1'b1, 100);
    get_byte("t4_c2h", 8'hC0, 1'b0, 100);
    get_byte("t4_c2i", 8'h08, 1'b1, 100);
    done = 1'b1;
    tick();
    done = 1'b0;
    get_byte("t4_s0", 8'hD0, 1'b0, 100);
    get_byte("t4_s1", 8'h00, 1'b0, 100);
    get_byte("t4_s2", 8'h00, 1'b0, 100);
    get_byte("t4_s3", 8'hFF, 1'b0, 100);
    get_byte("t4_s4", 8'hFF, 1'b1, 100);
    check("t4_fail_clr", 32'(fail_cnt), 32'd0);

    // 5: reset in the middle of a summary record
    do_reset();
    send_evt(1'b1, 8'h09);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("t5_pass", 32'(pass_cnt), 32'd1);
    get_byte("t5_c1h", 8'hC1, 1'b0, 100);
    get_byte("t5_c1i", 8'h09, 1'b1, 100);
    get_byte("t5_s0",  8'hD0, 1'b0, 100);
    get_byte("t5_s1",  8'h00, 1'b0, 100);
    check("t5_inflight", 32'(bus.tx_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("t5_valid", 32'(bus.tx_valid), 32'd0);
    check("t5_pass0", 32'(pass_cnt),     32'd0);
    check("t5_fail0", 32'(fail_cnt),     32'd0);
    check("t5_busy",  32'(busy),         32'd0);
    rst = 1'b0;
    bus.tx_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check("t5_residual", 32'(bus.tx_valid), 32'd0);
    end

    // 6: event and done together, done held while pending, random backpressure
    do_reset();
    bus.evt_valid = 1'b1;
    bus.evt_pass  = 1'b0;
    bus.evt_id    = 8'h2A;
    done          = 1'b1;
    tick();
    bus.evt_valid = 1'b0;
    check("t6_fail", 32'(fail_cnt), 32'd1);
    check("t6_rdy",  32'(bus.evt_ready), 32'd0);
    tick();
    tick();
    done = 1'b0;
    get_byte("t6_ch", 8'hC0, 1'b0, 50);
    get_byte("t6_ci", 8'h2A, 1'b1, 50);
    get_byte("t6_s0", 8'hD0, 1'b0, 50);
    get_byte("t6_s1", 8'h00, 1'b0, 50);
    get_byte("t6_s2", 8'h00, 1'b0, 50);
    get_byte("t6_s3", 8'h00, 1'b0, 50);
    get_byte("t6_s4", 8'h01, 1'b1, 50);
    tick();
    check("t6_pass_clr", 32'(pass_cnt), 32'd0);
    check("t6_fail_clr", 32'(fail_cnt), 32'd0);
    check("t6_busy",     32'(busy),     32'd0);
    check("t6_no_dup",   32'(bus.tx_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
